mc_cr_seq_ctrl: RTL and testbench
=================================

Name: mc_cr_seq_ctrl

Overview:
Parametrised sequencer for the chroma motion-compensation datapath. It replaces the fixed four-state src/dst controller. Each source row is accepted under a valid/ready handshake, the block waits out a configurable datapath latency, then presents the result row under a valid/ready handshake. It walks rows, 4x4 blocks and chroma channels (Cb, Cr) of one macroblock, emits a per-macroblock done pulse, and supports a synchronous flush.

Parameters:
NUM_CH, 2, number of chroma channels per macroblock (1..4)
BLKS_PER_CH, 4, 4x4 blocks per channel (1..16)
ROWS_PER_BLK, 4, rows per block (1..16)
PIPE_LAT, 3, datapath cycles from dp_load to result valid (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets on clk edge)
flush  in  1  synchronous abort; returns block to ACCEPT with counters cleared
src_valid  in  1  upstream row available
src_ready  out  1  block can accept a row
dst_valid  out  1  result row valid
dst_ready  in  1  downstream accepts result row
dp_load  out  1  one-cycle pulse: datapath captures source row
dp_busy  out  1  high while datapath result pending (WAIT state)
row_idx  out  max(1,$clog2(ROWS_PER_BLK))  current row
blk_idx  out  max(1,$clog2(BLKS_PER_CH))  current block
ch_idx  out  max(1,$clog2(NUM_CH))  current channel
mb_done  out  1  one-cycle pulse after the last row of the macroblock is delivered

Behaviour:
- States: ACCEPT, WAIT, OUTPUT, DONE. Registered state; Moore outputs except dp_load.
- Reset (reset==0 at clk edge): state=ACCEPT, all counters 0, lat_cnt 0. Registered outputs clear; dst_valid=0, dp_busy=0, mb_done=0. src_ready=1 from the first cycle after reset. Reset overrides flush.
- ACCEPT: src_ready=1.
  - On src_valid&&src_ready: dp_load=1 (combinational, same cycle).
  - If PIPE_LAT>0: lat_cnt<=PIPE_LAT-1, next state WAIT. If PIPE_LAT==0: next state OUTPUT.
  - No transfer: stay in ACCEPT.
- WAIT: dp_busy=1, src_ready=0. lat_cnt decrements each cycle; when lat_cnt==0, next state OUTPUT. Latency from accept edge to dst_valid=1 is exactly PIPE_LAT+1 cycles.
- OUTPUT: dst_valid=1, src_ready=0.
  - dst_valid holds while dst_ready=0; indices are stable while dst_valid=1.
  - On dst_ready: advance counters. row_idx wraps at ROWS_PER_BLK-1 and carries into blk_idx. blk_idx wraps at BLKS_PER_CH-1 and carries into ch_idx.
  - If row, blk and ch are all at their last values: counters go to 0, next state DONE. Otherwise next state ACCEPT.
- DONE: mb_done=1 for exactly one cycle, all handshake outputs 0, next state ACCEPT.
- flush=1 (reset inactive): next state ACCEPT, counters and lat_cnt cleared. flush wins over a simultaneous handshake: no dp_load, no counter advance, no mb_done. A dst_valid pending at flush drops without a transfer.
- Back-to-back: there is no src/dst overlap. Minimum cycles per row is PIPE_LAT+2. Total rows per macroblock = NUM_CH*BLKS_PER_CH*ROWS_PER_BLK (default 32).
- Illegal state encodings go to ACCEPT.

Decomposition:
- Package mc_cr_pkg holds the state enum typedef (2 bits) and the default parameter constants (MC_CR_NUM_CH, MC_CR_BLKS, MC_CR_ROWS, MC_CR_LAT), for sharing with the luma controller and datapath.
- One natural sub-module, mc_idx_counter: a nested row/blk/ch counter with an advance input, a last-flag output and a clear input, instantiated once.

Test Plan:
- Reset: hold reset=0 for 3 cycles with src_valid=1 -> src_ready=0 during reset, then 1 the first cycle after release; dst_valid=0, mb_done=0; indices 0.
- Single row, PIPE_LAT=3, dst_ready=1: src_valid at cycle t -> dp_load at t, dp_busy t+1..t+3, dst_valid at t+4, row_idx 0->1 after the dst transfer.
- Backpressure: hold dst_ready=0 for 5 cycles in OUTPUT -> dst_valid stays 1, indices unchanged, src_ready=0; transfer on the first dst_ready=1 cycle.
- Full macroblock, defaults, always-ready -> 32 dp_load pulses and 32 dst transfers, one mb_done after transfer 32. ch_idx=1 first appears on row 17. Total 32*5+1=161 cycles.
- PIPE_LAT=0, NUM_CH=1, BLKS_PER_CH=1, ROWS_PER_BLK=2 -> dst_valid one cycle after accept; mb_done after second row; 1-bit indices.
- Flush in WAIT and again coincident with dst_ready in OUTPUT -> state ACCEPT next cycle, indices 0, no mb_done, no extra counter advance.

Source files
------------

// File: rtl/mc_cr_pkg.sv
// mc_cr_pkg: shared FSM state encoding, default macroblock geometry and index-width helper
package mc_cr_pkg;
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_OUTPUT = 2'd2,
        ST_DONE   = 2'd3
    } mc_state_e;
    localparam int MC_CR_NUM_CH = 2;
    localparam int MC_CR_BLKS   = 4;
    localparam int MC_CR_ROWS   = 4;
    localparam int MC_CR_LAT    = 3;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mc_idx_counter.sv
// mc_idx_counter: nested row/blk/ch counter for one macroblock walk
//   clk, reset (sync, active-low), clr_i (sync clear), adv_i (step one row)
//   row_o/blk_o/ch_o current indices, last_o high when all three sit at their final value
module mc_idx_counter import mc_cr_pkg::*; #(
    parameter int NUM_CH       = MC_CR_NUM_CH,
    parameter int BLKS_PER_CH  = MC_CR_BLKS,
    parameter int ROWS_PER_BLK = MC_CR_ROWS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr_i,
    input  logic                             adv_i,
    output logic [idx_w(ROWS_PER_BLK)-1:0]   row_o,
    output logic [idx_w(BLKS_PER_CH)-1:0]    blk_o,
    output logic [idx_w(NUM_CH)-1:0]         ch_o,
    output logic                             last_o
);
    localparam int RW = idx_w(ROWS_PER_BLK);
    localparam int BW = idx_w(BLKS_PER_CH);
    localparam int CW = idx_w(NUM_CH);
    logic [RW-1:0] row_q;
    logic [BW-1:0] blk_q;
    logic [CW-1:0] ch_q;
    logic row_last, blk_last, ch_last;
    assign row_last = row_q == RW'(ROWS_PER_BLK - 1);
    assign blk_last = blk_q == BW'(BLKS_PER_CH - 1);
    assign ch_last  = ch_q == CW'(NUM_CH - 1);
    assign last_o   = row_last && blk_last && ch_last;
    // wrapping at each level returns everything to 0 after the final row
    always_ff @(posedge clk) begin
        if (!reset || clr_i) begin
            row_q <= '0;
            blk_q <= '0;
            ch_q  <= '0;
        end else if (adv_i) begin
            row_q <= row_last ? '0 : row_q + 1'b1;
            if (row_last) begin
                blk_q <= blk_last ? '0 : blk_q + 1'b1;
                if (blk_last) ch_q <= ch_last ? '0 : ch_q + 1'b1;
            end
        end
    end
    assign row_o = row_q;
    assign blk_o = blk_q;
    assign ch_o  = ch_q;
endmodule

// File: rtl/mc_cr_seq_ctrl.sv
// mc_cr_seq_ctrl: chroma MC row sequencer (accept row, wait datapath latency, deliver row)
//   clk, reset (sync, active-low), flush (sync abort to ACCEPT)
//   src_valid/src_ready upstream handshake, dst_valid/dst_ready downstream handshake
//   dp_load capture pulse, dp_busy datapath pending, row/blk/ch_idx position, mb_done end pulse
module mc_cr_seq_ctrl import mc_cr_pkg::*; #(
    parameter int NUM_CH       = MC_CR_NUM_CH,
    parameter int BLKS_PER_CH  = MC_CR_BLKS,
    parameter int ROWS_PER_BLK = MC_CR_ROWS,
    parameter int PIPE_LAT     = MC_CR_LAT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             src_valid,
    output logic                             src_ready,
    output logic                             dst_valid,
    input  logic                             dst_ready,
    output logic                             dp_load,
    output logic                             dp_busy,
    output logic [idx_w(ROWS_PER_BLK)-1:0]   row_idx,
    output logic [idx_w(BLKS_PER_CH)-1:0]    blk_idx,
    output logic [idx_w(NUM_CH)-1:0]         ch_idx,
    output logic                             mb_done
);
    localparam logic [3:0] LAT_INIT = 4'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    mc_state_e  state_q, state_d;
    logic [3:0] lat_q, lat_d;
    logic       src_ready_q, dst_valid_q, dp_busy_q, mb_done_q;
    logic       last, adv;
    // flush suppresses both handshakes in the cycle it is asserted
    assign dp_load = src_valid && src_ready_q && !flush;
    assign adv     = dst_valid_q && dst_ready && !flush;
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        if (flush) begin
            state_d = ST_ACCEPT;
            lat_d   = '0;
        end else begin
            case (state_q)
                ST_ACCEPT: if (dp_load) begin
                    state_d = (PIPE_LAT > 0) ? ST_WAIT : ST_OUTPUT;
                    lat_d   = LAT_INIT;
                end
                ST_WAIT: begin
                    state_d = (lat_q == '0) ? ST_OUTPUT : ST_WAIT;
                    lat_d   = (lat_q == '0) ? '0 : lat_q - 1'b1;
                end
                ST_OUTPUT: if (adv) state_d = last ? ST_DONE : ST_ACCEPT;
                default: state_d = ST_ACCEPT;
            endcase
        end
    end
    // Moore outputs are registered from the next state so they align with state_q
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_ACCEPT;
            lat_q       <= '0;
            src_ready_q <= 1'b0;
            dst_valid_q <= 1'b0;
            dp_busy_q   <= 1'b0;
            mb_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            src_ready_q <= state_d == ST_ACCEPT;
            dst_valid_q <= state_d == ST_OUTPUT;
            dp_busy_q   <= state_d == ST_WAIT;
            mb_done_q   <= state_d == ST_DONE;
        end
    end
    mc_idx_counter #(
        .NUM_CH(NUM_CH),
        .BLKS_PER_CH(BLKS_PER_CH),
        .ROWS_PER_BLK(ROWS_PER_BLK)
    ) u_idx (
        .clk(clk),
        .reset(reset),
        .clr_i(flush),
        .adv_i(adv),
        .row_o(row_idx),
        .blk_o(blk_idx),
        .ch_o(ch_idx),
        .last_o(last)
    );
    assign src_ready = src_ready_q;
    assign dst_valid = dst_valid_q;
    assign dp_busy   = dp_busy_q;
    assign mb_done   = mb_done_q;
endmodule

// File: tb/tb_mc_cr_seq_ctrl.sv
// tb_mc_cr_seq_ctrl: scoreboard bench for default and minimal sequencer configurations
module tb_mc_cr_seq_ctrl;
    localparam int A_ROWS = 4;
    localparam int A_BLKS = 4;
    localparam int A_TOT  = 32;
    localparam int B_ROWS = 2;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_flush = 1'b0, a_sv = 1'b0, a_dr = 1'b1;
    logic a_src_ready, a_dst_valid, a_dp_load, a_dp_busy, a_mb_done;
    logic [1:0] a_row_idx, a_blk_idx;
    logic [0:0] a_ch_idx;
    logic b_flush = 1'b0, b_sv = 1'b0, b_dr = 1'b1;
    logic b_src_ready, b_dst_valid, b_dp_load, b_dp_busy, b_mb_done;
    logic [0:0] b_row_idx, b_blk_idx, b_ch_idx;
    int errors = 0, checks = 0;
    int exp_a[$];
    int exp_b[$];
    int ka = 0, kb = 0;
    int a_done_n = 0;
    always #5 clk = ~clk;
    mc_cr_seq_ctrl u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .src_valid(a_sv), .src_ready(a_src_ready),
        .dst_valid(a_dst_valid), .dst_ready(a_dr), .dp_load(a_dp_load), .dp_busy(a_dp_busy),
        .row_idx(a_row_idx), .blk_idx(a_blk_idx), .ch_idx(a_ch_idx), .mb_done(a_mb_done)
    );
    mc_cr_seq_ctrl #(.NUM_CH(1), .BLKS_PER_CH(1), .ROWS_PER_BLK(2), .PIPE_LAT(0)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .src_valid(b_sv), .src_ready(b_src_ready),
        .dst_valid(b_dst_valid), .dst_ready(b_dr), .dp_load(b_dp_load), .dp_busy(b_dp_busy),
        .row_idx(b_row_idx), .blk_idx(b_blk_idx), .ch_idx(b_ch_idx), .mb_done(b_mb_done)
    );
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push_a;
        exp_a.push_back(ka);
        ka = (ka + 1) % A_TOT;
    endtask
    task automatic push_b;
        exp_b.push_back(kb);
        kb = (kb + 1) % B_ROWS;
    endtask
    // scoreboard monitors: every delivered row must match the next expected position
    always @(negedge clk) begin
        if (reset && !a_flush && a_dst_valid && a_dr) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_xfer: row=%0d with no row outstanding", a_row_idx);
            end else begin
                int k;
                k = exp_a.pop_front();
                chk("a_row_idx", a_row_idx, k % A_ROWS);
                chk("a_blk_idx", a_blk_idx, (k / A_ROWS) % A_BLKS);
                chk("a_ch_idx", a_ch_idx, k / (A_ROWS * A_BLKS));
            end
        end
        if (reset && !b_flush && b_dst_valid && b_dr) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_xfer: row=%0d with no row outstanding", b_row_idx);
            end else begin
                int k;
                k = exp_b.pop_front();
                chk("b_row_idx", b_row_idx, k % B_ROWS);
                chk("b_blk_idx", b_blk_idx, 0);
                chk("b_ch_idx", b_ch_idx, 0);
            end
        end
        if (a_mb_done) a_done_n++;
    end
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
    initial begin
        int got, ld_n, xf_n, first_ch1, done_at;
        a_sv = 1'b1;
        b_sv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_src_ready", a_src_ready, 0);
            chk("rst_dst_valid", a_dst_valid, 0);
            chk("rst_mb_done", a_mb_done, 0);
        end
        tick;
        reset = 1'b1;
        a_sv = 1'b0;
        b_sv = 1'b0;
        tick;
        @(negedge clk);
        chk("post_rst_src_ready", a_src_ready, 1);
        chk("post_rst_row", a_row_idx, 0);
        chk("post_rst_blk", a_blk_idx, 0);
        chk("post_rst_ch", a_ch_idx, 0);
        chk("post_rst_dst_valid", a_dst_valid, 0);
        chk("b_post_rst_src_ready", b_src_ready, 1);
        // single row, latency 3
        tick;
        a_sv = 1'b1;
        @(negedge clk);
        chk("single_dp_load", a_dp_load, 1);
        push_a();
        tick;
        a_sv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_dp_busy", a_dp_busy, 1);
            chk("single_no_valid", a_dst_valid, 0);
            tick;
        end
        @(negedge clk);
        chk("single_dst_valid", a_dst_valid, 1);
        tick;
        @(negedge clk);
        chk("single_row_adv", a_row_idx, 1);
        chk("single_src_ready", a_src_ready, 1);
        chk("single_busy_clear", a_dp_busy, 0);
        // backpressure
        a_dr = 1'b0;
        tick;
        a_sv = 1'b1;
        @(negedge clk);
        push_a();
        tick;
        a_sv = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (a_dst_valid) got = 1;
            else tick;
        end
        chk("bp_reach_output", got, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", a_dst_valid, 1);
            chk("bp_row_stable", a_row_idx, 1);
            chk("bp_src_ready", a_src_ready, 0);
            tick;
            if (i == 4) a_dr = 1'b1;
            @(negedge clk);
        end
        tick;
        @(negedge clk);
        chk("bp_row_adv", a_row_idx, 2);
        // flush while the datapath is busy
        tick;
        a_sv = 1'b1;
        @(negedge clk);
        tick;
        a_sv = 1'b0;
        @(negedge clk);
        chk("flw_busy", a_dp_busy, 1);
        tick;
        a_flush = 1'b1;
        ka = 0;
        tick;
        a_flush = 1'b0;
        @(negedge clk);
        chk("flw_src_ready", a_src_ready, 1);
        chk("flw_busy_clear", a_dp_busy, 0);
        chk("flw_row", a_row_idx, 0);
        chk("flw_dst_valid", a_dst_valid, 0);
        // flush coincident with dst_ready in OUTPUT
        a_dr = 1'b0;
        tick;
        a_sv = 1'b1;
        @(negedge clk);
        tick;
        a_sv = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (a_dst_valid) got = 1;
            else tick;
        end
        chk("flo_reach_output", got, 1);
        tick;
        a_dr = 1'b1;
        a_flush = 1'b1;
        tick;
        a_flush = 1'b0;
        @(negedge clk);
        chk("flo_src_ready", a_src_ready, 1);
        chk("flo_row", a_row_idx, 0);
        chk("flo_dst_valid", a_dst_valid, 0);
        tick;
        @(negedge clk);
        chk("flo_row_hold", a_row_idx, 0);
        chk("flo_no_mb_done", a_done_n, 0);
        // full macroblock, always ready
        ld_n = 0;
        xf_n = 0;
        first_ch1 = -1;
        done_at = -1;
        tick;
        a_sv = 1'b1;
        for (int i = 0; i < 400 && done_at < 0; i++) begin
            @(negedge clk);
            if (a_dp_load) begin
                ld_n++;
                push_a();
            end
            if (a_dst_valid && a_dr) begin
                xf_n++;
                if (a_ch_idx == 1'b1 && first_ch1 < 0) first_ch1 = xf_n;
            end
            if (a_mb_done) done_at = i;
            tick;
            if (done_at >= 0) a_sv = 1'b0;
        end
        chk("mb_loads", ld_n, 32);
        chk("mb_xfers", xf_n, 32);
        chk("mb_first_ch1_row", first_ch1, 17);
        chk("mb_done_cycle", done_at, 160);
        @(negedge clk);
        chk("mb_done_pulse_once", a_mb_done, 0);
        chk("mb_done_count", a_done_n, 1);
        chk("mb_back_to_accept", a_src_ready, 1);
        chk("mb_row_wrap", a_row_idx, 0);
        chk("mb_ch_wrap", a_ch_idx, 0);
        chk("a_queue_drained", exp_a.size(), 0);
        // minimal config, zero latency
        tick;
        b_sv = 1'b1;
        @(negedge clk);
        chk("b_dp_load", b_dp_load, 1);
        push_b();
        tick;
        b_sv = 1'b0;
        @(negedge clk);
        chk("b_valid_next", b_dst_valid, 1);
        chk("b_no_busy", b_dp_busy, 0);
        tick;
        @(negedge clk);
        chk("b_row1", b_row_idx, 1);
        chk("b_src_ready", b_src_ready, 1);
        tick;
        b_sv = 1'b1;
        @(negedge clk);
        push_b();
        tick;
        b_sv = 1'b0;
        @(negedge clk);
        chk("b_valid2", b_dst_valid, 1);
        tick;
        @(negedge clk);
        chk("b_mb_done", b_mb_done, 1);
        chk("b_done_no_ready", b_src_ready, 0);
        tick;
        @(negedge clk);
        chk("b_mb_done_clear", b_mb_done, 0);
        chk("b_row_wrap", b_row_idx, 0);
        chk("b_src_ready_again", b_src_ready, 1);
        chk("b_queue_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
